// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and constants for the conv pass sequencer
// Purpose: sequencer state encoding, kernel tap count, default map size and
//          weight width, and a width helper that never returns zero.
// Ports:   none (package).
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KLOAD,
    S_STREAM,
    S_DRAIN,
    S_GAP,
    S_DONE
  } state_t;

  localparam int KTAPS  = 9;
  localparam int IMG_PX = 196;
  localparam int W2_DEF = 10;

  // Counter width for values 0..n-1; a single-value counter still gets 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_kreg_bank.sv
// rtl/conv_kreg_bank.sv - 3x3 kernel weight capture registers
// Purpose: holds the nine weights of the current pass; slot i_idx is loaded
//          from i_data when i_wr is high. Slots are only written during the
//          kernel load, so o_k_bus is stable for the rest of the pass.
// Ports:   i_clk, i_rst (async, active-high) | i_wr, i_idx[3:0], i_data[W2]
//          | o_k_bus[9*W2] (k1 at LSBs).
module conv_kreg_bank #(
  parameter int W2 = cnn_pkg::W2_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr,
  input  logic [3:0]                    i_idx,
  input  logic [W2-1:0]                 i_data,
  output logic [cnn_pkg::KTAPS*W2-1:0]  o_k_bus
);
  import cnn_pkg::*;

  logic [W2-1:0] r_k [KTAPS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < KTAPS; i++) r_k[i] <= '0;
    end else begin
      for (int i = 0; i < KTAPS; i++) begin
        if (i_wr && i_idx == 4'(i)) r_k[i] <= i_data;
      end
    end
  end

  for (genvar g = 0; g < KTAPS; g++) begin : g_pack
    assign o_k_bus[g*W2 +: W2] = r_k[g];
  end

endmodule

// File: rtl/conv_pass_sched.sv
// rtl/conv_pass_sched.sv - pass sequencer for the 3x3 conv engine
// Purpose: for every filter f and input channel c, loads 9 weights, streams
//          one feature map into the engine, counts and tags engine outputs.
// Ports:   i_clk, i_rst (async, active-high), i_start, i_abort
//          | o_kw_rd, o_kw_addr, i_kw_data (kernel memory, 1-cycle read)
//          | o_k_bus (packed weights) | o_pix_rd, o_pix_addr (feature map)
//          | o_eng_hold, i_eng_en (engine) | o_out_vld, o_out_filt,
//          o_out_first, o_out_last, o_out_idx (output tags)
//          | o_busy, o_done, o_err (layer status).
module conv_pass_sched #(
  parameter int W2     = cnn_pkg::W2_DEF,
  parameter int IMG_PX = cnn_pkg::IMG_PX,
  parameter int N_CH   = 4,
  parameter int N_FILT = 8,
  parameter int TMO    = 64,
  parameter int KA_W   = 9,
  parameter int PA_W   = 10
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  output logic                          o_kw_rd,
  output logic [KA_W-1:0]               o_kw_addr,
  input  logic [W2-1:0]                 i_kw_data,
  output logic [cnn_pkg::KTAPS*W2-1:0]  o_k_bus,
  output logic                          o_pix_rd,
  output logic [PA_W-1:0]               o_pix_addr,
  output logic                          o_eng_hold,
  input  logic                          i_eng_en,
  output logic                          o_out_vld,
  output logic [2:0]                    o_out_filt,
  output logic                          o_out_first,
  output logic                          o_out_last,
  output logic [7:0]                    o_out_idx,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);
  import cnn_pkg::*;

  localparam int C_W = clog2_min1(N_CH);
  localparam int F_W = clog2_min1(N_FILT);
  localparam int T_W = clog2_min1(TMO + 1);

  state_t          r_state;
  logic [C_W-1:0]  r_c;
  logic [F_W-1:0]  r_f;
  logic [3:0]      r_k;
  logic [7:0]      r_p;
  logic [7:0]      r_out_cnt;
  logic [T_W-1:0]  r_idle;
  logic            r_gap;
  logic            r_cap;
  logic [3:0]      r_cap_idx;
  logic            r_kw_rd;
  logic [KA_W-1:0] r_kw_addr;
  logic            r_pix_rd;
  logic [PA_W-1:0] r_pix_addr;
  logic            r_eng_hold;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_in_pass;
  logic            w_cnt_en;
  logic            w_c_wrap;
  logic [C_W-1:0]  w_nc;
  logic [F_W-1:0]  w_nf;
  logic            w_last;

  function automatic logic [KA_W-1:0] kbase(input logic [F_W-1:0] f, input logic [C_W-1:0] c);
    return KA_W'((int'(f) * N_CH + int'(c)) * KTAPS);
  endfunction

  function automatic logic [PA_W-1:0] pbase(input logic [C_W-1:0] c);
    return PA_W'(int'(c) * IMG_PX);
  endfunction

  assign w_in_pass = (r_state == S_STREAM) || (r_state == S_DRAIN);
  // Stop counting at a full map so a stray extra pulse cannot skip the exit compare.
  assign w_cnt_en  = w_in_pass && i_eng_en && (r_out_cnt != 8'(IMG_PX));
  assign w_c_wrap  = (r_c == C_W'(N_CH - 1));
  assign w_nc      = w_c_wrap ? '0 : r_c + C_W'(1);
  assign w_nf      = w_c_wrap ? r_f + F_W'(1) : r_f;
  assign w_last    = w_c_wrap && (r_f == F_W'(N_FILT - 1));

  // Weight k arrives one cycle after its read; r_cap/r_cap_idx are the read strobe delayed to match.
  conv_kreg_bank #(.W2(W2)) u_kreg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (r_cap),
    .i_idx   (r_cap_idx),
    .i_data  (i_kw_data),
    .o_k_bus (o_k_bus)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_c        <= '0;
      r_f        <= '0;
      r_k        <= '0;
      r_p        <= '0;
      r_out_cnt  <= '0;
      r_idle     <= '0;
      r_gap      <= 1'b0;
      r_cap      <= 1'b0;
      r_cap_idx  <= '0;
      r_kw_rd    <= 1'b0;
      r_kw_addr  <= '0;
      r_pix_rd   <= 1'b0;
      r_pix_addr <= '0;
      r_eng_hold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (i_abort) begin
      r_state    <= S_IDLE;
      r_cap      <= 1'b0;
      r_kw_rd    <= 1'b0;
      r_pix_rd   <= 1'b0;
      r_eng_hold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cap     <= r_kw_rd;
      r_cap_idx <= r_k;
      if (w_cnt_en) r_out_cnt <= r_out_cnt + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_f       <= '0;
            r_c       <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_k       <= '0;
            r_kw_rd   <= 1'b1;
            r_kw_addr <= '0;
            r_state   <= S_KLOAD;
          end
        end
        // r_k 0..8 issue reads, r_k 9 is the cycle that captures the last weight.
        S_KLOAD: begin
          if (r_k == 4'd9) begin
            r_pix_rd   <= 1'b1;
            r_pix_addr <= pbase(r_c);
            r_p        <= '0;
            r_out_cnt  <= '0;
            r_state    <= S_STREAM;
          end else begin
            r_k <= r_k + 4'd1;
            if (r_k == 4'd8) r_kw_rd <= 1'b0;
            else r_kw_addr <= r_kw_addr + KA_W'(1);
          end
        end
        // Release the engine one cycle after the first read so pixel data lines up.
        S_STREAM: begin
          if (r_p == 8'd0) r_eng_hold <= 1'b0;
          if (r_p == 8'(IMG_PX - 1)) begin
            r_pix_rd <= 1'b0;
            r_idle   <= '0;
            r_state  <= S_DRAIN;
          end else begin
            r_p        <= r_p + 8'd1;
            r_pix_addr <= r_pix_addr + PA_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_out_cnt == 8'(IMG_PX)) begin
            r_eng_hold <= 1'b1;
            r_gap      <= 1'b0;
            r_state    <= S_GAP;
          end else if (i_eng_en) begin
            r_idle <= '0;
          end else if (r_idle == T_W'(TMO - 1)) begin
            r_err      <= 1'b1;
            r_eng_hold <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_idle <= r_idle + T_W'(1);
          end
        end
        S_GAP: begin
          if (!r_gap) begin
            r_gap <= 1'b1;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_c       <= w_nc;
            r_f       <= w_nf;
            r_k       <= '0;
            r_kw_rd   <= 1'b1;
            r_kw_addr <= kbase(w_nf, w_nc);
            r_state   <= S_KLOAD;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_kw_rd     = r_kw_rd;
  assign o_kw_addr   = r_kw_addr;
  assign o_pix_rd    = r_pix_rd;
  assign o_pix_addr  = r_pix_addr;
  assign o_eng_hold  = r_eng_hold;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  // Tags are only meaningful alongside out_vld; held at zero outside a pass.
  assign o_out_vld   = w_in_pass && i_eng_en;
  assign o_out_filt  = w_in_pass ? 3'(r_f) : 3'd0;
  assign o_out_first = w_in_pass && (r_c == '0);
  assign o_out_last  = w_in_pass && w_c_wrap;
  assign o_out_idx   = w_in_pass ? r_out_cnt : 8'd0;

endmodule

// File: tb/tb_conv_pass_sched.sv
// tb/tb_conv_pass_sched.sv - scoreboard bench for conv_pass_sched
module tb_conv_pass_sched;
  localparam int W2 = 10, IMG = 196, NCH = 2, NF = 2, TMO = 64, KA_W = 9, PA_W = 10;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, eng_en = 1'b0;
  logic [W2-1:0] kw_data = '0;
  logic kw_rd, pix_rd, eng_hold, out_vld, out_first, out_last, busy, done, err;
  logic [KA_W-1:0] kw_addr;
  logic [PA_W-1:0] pix_addr;
  logic [9*W2-1:0] k_bus;
  logic [2:0] out_filt;
  logic [7:0] out_idx;

  always #5 clk = ~clk;

  conv_pass_sched #(.W2(W2), .IMG_PX(IMG), .N_CH(NCH), .N_FILT(NF), .TMO(TMO),
                    .KA_W(KA_W), .PA_W(PA_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .o_kw_rd(kw_rd), .o_kw_addr(kw_addr), .i_kw_data(kw_data), .o_k_bus(k_bus),
    .o_pix_rd(pix_rd), .o_pix_addr(pix_addr), .o_eng_hold(eng_hold), .i_eng_en(eng_en),
    .o_out_vld(out_vld), .o_out_filt(out_filt), .o_out_first(out_first),
    .o_out_last(out_last), .o_out_idx(out_idx), .o_busy(busy), .o_done(done), .o_err(err));

  typedef struct {int addr; int kb;} pix_t;
  typedef struct {int tag; int kb;} out_t;

  int   kw_q[$];
  pix_t pix_q[$];
  out_t out_q[$];
  pix_t pe;
  out_t oe;
  int tests = 0, fails = 0;
  bit sb_on = 1'b0;
  bit ok;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_pix_cyc = 0, d0;
  int eng_lim = 196, eng_cyc = 0, eng_sent = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int kbus_ok(input int kb);
    for (int k = 0; k < 9; k++)
      if (k_bus[k*W2 +: W2] != W2'(100 + kb + k)) return 0;
    return 1;
  endfunction

  // Kernel memory: weight = 100 + address, one-cycle read latency.
  always @(posedge clk) if (kw_rd) kw_data <= W2'(100 + int'(kw_addr));

  // Engine model: output-valid starts 16 cycles after hold drops, eng_lim pulses.
  always @(posedge clk) begin
    #1;
    if (rst || eng_hold) begin
      eng_cyc = 0; eng_sent = 0; eng_en = 1'b0;
    end else begin
      eng_cyc++;
      if (eng_cyc > 16 && eng_sent < eng_lim) begin eng_en = 1'b1; eng_sent++; end
      else eng_en = 1'b0;
    end
  end

  // Monitor: pops expected items whenever the DUT presents a strobe.
  always @(negedge clk) begin
    cyc++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (pix_rd) last_pix_cyc = cyc;
    if (sb_on && !rst) begin
      if (kw_rd) begin
        if (kw_q.size() == 0) chk("kw_extra", int'(kw_addr), -1);
        else chk("kw_addr", int'(kw_addr), kw_q.pop_front());
      end
      if (pix_rd) begin
        if (pix_q.size() == 0) chk("pix_extra", int'(pix_addr), -1);
        else begin
          pe = pix_q.pop_front();
          chk("pix_addr", int'(pix_addr), pe.addr);
          chk("kbus_stream", kbus_ok(pe.kb), 1);
        end
      end
      if (out_vld) begin
        if (out_q.size() == 0) chk("out_extra", int'(out_idx), -1);
        else begin
          oe = out_q.pop_front();
          chk("out_tag", int'({out_filt, out_first, out_last, out_idx}), oe.tag);
          chk("kbus_drain", kbus_ok(oe.kb), 1);
        end
      end
    end
  end

  task automatic push_pass(input int f, input int c, input int nout);
    int kb;
    kb = (f * NCH + c) * 9;
    for (int k = 0; k < 9; k++) kw_q.push_back(kb + k);
    for (int p = 0; p < IMG; p++) pix_q.push_back('{addr: c * IMG + p, kb: kb});
    for (int i = 0; i < nout; i++)
      out_q.push_back('{tag: f * 1024 + (c == 0 ? 512 : 0) + (c == NCH - 1 ? 256 : 0) + i, kb: kb});
  endtask

  task automatic push_layer();
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < NCH; c++) push_pass(f, c, IMG);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin got = 1'b1; break; end
    end
  endtask

  task automatic sb_empty(input string name);
    chk(name, kw_q.size() + pix_q.size() + out_q.size(), 0);
    kw_q.delete(); pix_q.delete(); out_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_hold", eng_hold, 1);
    chk("rst_outs", int'({busy, done, err, kw_rd, pix_rd, out_vld, out_first, out_last}), 0);
    chk("rst_addrs", int'(kw_addr) + int'(pix_addr) + int'(out_idx) + int'(out_filt), 0);
    chk("rst_kbus", int'(k_bus == '0), 1);
    rst = 1'b0;
    tick();

    // Full layer: 4 passes, kw_addr 0..35, tags f=0,0,1,1 / first on c=0 / last on c=1.
    sb_on = 1'b1;
    push_layer();
    pulse_start();
    chk("busy_accept", busy, 1);
    wait_done(3000, ok);
    chk("done_l1", ok, 1);
    chk("err_l1", err, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("done_cnt_l1", done_cnt, 1);
    sb_empty("sb_empty_l1");
    chk("kbus_f1c1_slot0", int'(k_bus[0 +: W2]), 127);
    chk("kbus_f1c1_slot8", int'(k_bus[8*W2 +: W2]), 135);

    // Engine stalls after 150 outputs: watchdog error, no further passes.
    eng_lim = 150;
    push_pass(0, 0, 150);
    pulse_start();
    wait_done(2000, ok);
    chk("done_stall", ok, 1);
    chk("err_set", err, 1);
    chk("hold_on_err", eng_hold, 1);
    @(negedge clk); #1;
    chk("tmo_delay", done_cyc - last_pix_cyc, TMO + 1);
    d0 = done_cnt;
    repeat (20) tick();
    chk("single_done_stall", done_cnt - d0, 0);
    chk("err_sticky", err, 1);
    sb_empty("sb_empty_stall");

    // Next start clears err and runs a full layer.
    eng_lim = 196;
    push_layer();
    pulse_start();
    chk("err_cleared", err, 0);
    wait_done(3000, ok);
    chk("done_l2", ok, 1);
    tick();
    sb_empty("sb_empty_l2");

    // Abort in STREAM at p=50.
    sb_on = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (pix_rd && pix_addr == PA_W'(50)) begin ok = 1'b1; break; end
      tick();
    end
    chk("reach_p50", ok, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pix_rd", pix_rd, 0);
    chk("abort_hold", eng_hold, 1);
    d0 = done_cnt;
    repeat (20) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", int'({busy, kw_rd}), 0);

    // Restart after abort completes normally.
    sb_on = 1'b1;
    push_layer();
    pulse_start();
    wait_done(3000, ok);
    chk("done_restart", ok, 1);
    tick();
    sb_empty("sb_empty_restart");

    // Async reset in DRAIN, between clock edges.
    sb_on = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (i > 20 && !pix_rd) begin ok = 1'b1; break; end
    end
    chk("reach_drain", ok, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hold", eng_hold, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_kbus", int'(k_bus == '0), 1);
    tick();
    rst = 1'b0;
    tick();
    sb_on = 1'b1;
    push_layer();
    pulse_start();
    wait_done(3000, ok);
    chk("done_after_rst", ok, 1);
    tick();
    sb_empty("sb_empty_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
